// File: rtl/control_conduit_mc_pkg.sv
// Shared constants and address decode for the control conduit.
// Latency: none (package only).
// Backpressure: n/a.
package ctrl_conduit_pkg;

  // Layout of the 32-bit status word returned from the status/control address
  localparam int COUNT_LSB = 0;
  localparam int EMPTY_BIT = 16;
  localparam int FULL_BIT  = 17;
  localparam int OVF_BIT   = 31;
  localparam int STATUS_W  = 32;

  // Addresses 0..ch_n-1 are channel push ports.
  function automatic logic is_channel_addr(input int unsigned addr, input int unsigned ch_n);
    return addr < ch_n;
  endfunction

  // The address just past the last channel is the status/control register.
  // Anything above it is an unmapped hole.
  function automatic logic is_status_addr(input int unsigned addr, input int unsigned ch_n);
    return addr == ch_n;
  endfunction

endpackage

// File: rtl/control_conduit_mc_if.sv
// Bus bundle: register-style write/read port plus the control conduit towards the consumer.
// Latency: none (wiring only).
// Backpressure: consumer throttles via conduit_export_control_ack; pushes are never stalled.
interface control_conduit_mc_if #(
  parameter int DATA_W = 32,
  parameter int CH_N   = 4
);
  localparam int CW = (CH_N > 1) ? $clog2(CH_N) : 1;
  localparam int AW = $clog2(CH_N + 1);

  logic [AW-1:0]     avs_address;
  logic              avs_write;
  logic [DATA_W-1:0] avs_writedata;
  logic              avs_read;
  logic [31:0]       avs_readdata;

  logic [DATA_W-1:0] conduit_export_control_data;
  logic [CW-1:0]     conduit_export_control_channel;
  logic              conduit_export_control_set;
  logic              conduit_export_control_ack;

  // Conduit block side: accepts register traffic, sources control words
  modport slave (
    input  avs_address, avs_write, avs_writedata, avs_read,
    output avs_readdata,
    output conduit_export_control_data, conduit_export_control_channel, conduit_export_control_set,
    input  conduit_export_control_ack
  );

  // Host/consumer side
  modport master (
    output avs_address, avs_write, avs_writedata, avs_read,
    input  avs_readdata,
    input  conduit_export_control_data, conduit_export_control_channel, conduit_export_control_set,
    output conduit_export_control_ack
  );

endinterface

// File: rtl/control_conduit_mc_fifo.sv
// Synchronous FIFO with first-word fall-through head and occupancy count.
// Latency: a pushed word is visible at o_rdata the cycle after the push edge.
// Backpressure: push while full is dropped (even with a same-cycle pop); pop while empty is ignored.
module ctrl_fifo #(
  parameter  int W     = 34,
  parameter  int DEPTH = 8,
  localparam int PW    = $clog2(DEPTH),
  localparam int NW    = PW + 1
) (
  input  logic          clk_clk,
  input  logic          reset_reset_n,
  input  logic          i_push,
  input  logic [W-1:0]  i_wdata,
  input  logic          i_pop,
  output logic [W-1:0]  o_rdata,
  output logic          o_full,
  output logic          o_empty,
  output logic [NW-1:0] o_count
);

  logic [W-1:0]  r_mem [DEPTH];
  logic [PW-1:0] r_wr_ptr;
  logic [PW-1:0] r_rd_ptr;
  logic [NW-1:0] r_count;
  logic          w_push_ok;
  logic          w_pop_ok;

  assign o_full    = (r_count == NW'(DEPTH));
  assign o_empty   = (r_count == '0);
  // Full is judged on the pre-edge count, so a pop in the same cycle does not make room.
  assign w_push_ok = i_push && !o_full;
  assign w_pop_ok  = i_pop && !o_empty;
  assign o_rdata   = r_mem[r_rd_ptr];
  assign o_count   = r_count;

  // Storage array; no reset needed since contents are only observed behind a non-zero count
  always_ff @(posedge clk_clk) begin
    if (w_push_ok) begin
      r_mem[r_wr_ptr] <= i_wdata;
    end
  end

  // Pointers wrap naturally (DEPTH is a power of two); count tracks occupancy 0..DEPTH
  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push_ok) begin
        r_wr_ptr <= r_wr_ptr + 1'b1;
      end
      if (w_pop_ok) begin
        r_rd_ptr <= r_rd_ptr + 1'b1;
      end
      case ({w_push_ok, w_pop_ok})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: rtl/control_conduit_mc.sv
// Multi-channel control conduit: register writes queue tagged control words for a downstream consumer.
// Latency: pushed word appears on the conduit 1 cycle after the write; status read data 1 cycle after read.
// Backpressure: handshake mode holds the head until ack; pulse mode ignores ack; pushes to a full queue drop and flag overflow.
module control_conduit_mc
  import ctrl_conduit_pkg::*;
#(
  parameter int DATA_W     = 32,
  parameter int CH_N       = 4,
  parameter int DEPTH      = 8,
  parameter int PULSE_MODE = 0
) (
  input logic                 clk_clk,
  input logic                 reset_reset_n,
  control_conduit_mc_if.slave bus
);

  localparam int CW = (CH_N > 1) ? $clog2(CH_N) : 1;
  localparam int AW = $clog2(CH_N + 1);
  localparam int NW = $clog2(DEPTH) + 1;
  localparam int FW = CW + DATA_W;

  logic [AW-1:0]       w_addr;
  logic                w_is_chan;
  logic                w_is_status;
  logic                w_push_req;
  logic                w_clr_bit;
  logic                w_ovf_clr;
  logic [FW-1:0]       w_fifo_wdata;
  logic [FW-1:0]       w_head;
  logic                w_full;
  logic                w_empty;
  logic [NW-1:0]       w_count;
  logic                w_set;
  logic                w_pop;
  logic [STATUS_W-1:0] w_status;
  logic                r_ovf;
  logic [31:0]         r_readdata;

  assign w_addr       = bus.avs_address;
  assign w_is_chan    = is_channel_addr(32'(w_addr), CH_N);
  assign w_is_status  = is_status_addr(32'(w_addr), CH_N);
  assign w_push_req   = bus.avs_write && w_is_chan;
  assign w_fifo_wdata = {w_addr[CW-1:0], bus.avs_writedata};

  // The overflow-clear bit only exists when the data bus reaches bit 31
  generate
    if (DATA_W > OVF_BIT) begin : g_clr_bit
      assign w_clr_bit = bus.avs_writedata[OVF_BIT];
    end else begin : g_no_clr_bit
      assign w_clr_bit = 1'b0;
    end
  endgenerate

  assign w_ovf_clr = bus.avs_write && w_is_status && w_clr_bit;

  ctrl_fifo #(
    .W     (FW),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk_clk       (clk_clk),
    .reset_reset_n (reset_reset_n),
    .i_push        (w_push_req),
    .i_wdata       (w_fifo_wdata),
    .i_pop         (w_pop),
    .o_rdata       (w_head),
    .o_full        (w_full),
    .o_empty       (w_empty),
    .o_count       (w_count)
  );

  generate
    if (PULSE_MODE != 0) begin : g_pulse
      logic r_gap;
      // Remember that a pulse just went out so the next word waits one low cycle
      always_ff @(posedge clk_clk or negedge reset_reset_n) begin
        if (!reset_reset_n) begin
          r_gap <= 1'b0;
        end else begin
          r_gap <= w_set;
        end
      end
      assign w_set = !w_empty && !r_gap;
      assign w_pop = w_set;
    end else begin : g_handshake
      assign w_set = !w_empty;
      assign w_pop = w_set && bus.conduit_export_control_ack;
    end
  endgenerate

  // Data and tag are forced to zero whenever no word is being offered
  assign bus.conduit_export_control_set     = w_set;
  assign bus.conduit_export_control_data    = w_set ? w_head[DATA_W-1:0] : '0;
  assign bus.conduit_export_control_channel = w_set ? w_head[FW-1:DATA_W] : '0;

  // Sticky overflow; a dropped push outranks a clear in the same cycle
  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      r_ovf <= 1'b0;
    end else if (w_push_req && w_full) begin
      r_ovf <= 1'b1;
    end else if (w_ovf_clr) begin
      r_ovf <= 1'b0;
    end
  end

  // Status word assembled from the pre-edge queue state
  always_comb begin
    w_status                      = '0;
    w_status[COUNT_LSB +: NW]     = w_count;
    w_status[EMPTY_BIT]           = w_empty;
    w_status[FULL_BIT]            = w_full;
    w_status[OVF_BIT]             = r_ovf;
  end

  // Registered read port: status at the control address, zero elsewhere
  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      r_readdata <= '0;
    end else if (bus.avs_read && w_is_status) begin
      r_readdata <= w_status;
    end else begin
      r_readdata <= '0;
    end
  end

  assign bus.avs_readdata = r_readdata;

endmodule

// File: tb/tb_control_conduit_mc.sv
// Self-checking bench for control_conduit_mc: directed scenarios plus randomized traffic against a queue model.
// Latency: checks conduit outputs one cycle after a push and read data one cycle after a read.
// Backpressure: exercises ack-held-low fill, overflow drop, and pulse mode spacing.
module tb_control_conduit_mc;

  localparam int DATA_W = 32;
  localparam int CH_N   = 4;
  localparam int DEPTH  = 8;

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  always #5 clk = ~clk;

  control_conduit_mc_if #(.DATA_W(DATA_W), .CH_N(CH_N)) b0 ();
  control_conduit_mc_if #(.DATA_W(DATA_W), .CH_N(CH_N)) b1 ();

  control_conduit_mc #(.DATA_W(DATA_W), .CH_N(CH_N), .DEPTH(DEPTH), .PULSE_MODE(0)) u_dut0 (
    .clk_clk       (clk),
    .reset_reset_n (rst_n),
    .bus           (b0)
  );

  control_conduit_mc #(.DATA_W(DATA_W), .CH_N(CH_N), .DEPTH(DEPTH), .PULSE_MODE(1)) u_dut1 (
    .clk_clk       (clk),
    .reset_reset_n (rst_n),
    .bus           (b1)
  );

  int n_vec = 0;
  int n_err = 0;

  // Reference model of the handshake-mode instance: ordered queue of {channel, data}
  logic [33:0] mq[$];
  logic        mov = 1'b0;
  logic [31:0] mrd = '0;

  task automatic idle_inputs();
    b0.avs_address = '0; b0.avs_write = 1'b0; b0.avs_writedata = '0; b0.avs_read = 1'b0;
    b0.conduit_export_control_ack = 1'b0;
    b1.avs_address = '0; b1.avs_write = 1'b0; b1.avs_writedata = '0; b1.avs_read = 1'b0;
    b1.conduit_export_control_ack = 1'b0;
  endtask

  // Advance the model across one rising edge using the inputs currently driven
  task automatic model_edge();
    int   sz;
    logic full, pop, push, clr;
    sz   = mq.size();
    full = (sz == DEPTH);
    pop  = (sz != 0) && b0.conduit_export_control_ack;
    push = b0.avs_write && (b0.avs_address < 3'(CH_N));
    clr  = b0.avs_write && (b0.avs_address == 3'(CH_N)) && b0.avs_writedata[31];
    if (!rst_n) begin
      mq.delete();
      mov = 1'b0;
      mrd = '0;
      return;
    end
    mrd = '0;
    if (b0.avs_read && b0.avs_address == 3'(CH_N))
      mrd = {mov, 13'd0, full, (sz == 0), 12'd0, 4'(sz)};
    if (push && full) mov = 1'b1;
    else if (clr) mov = 1'b0;
    if (pop) void'(mq.pop_front());
    if (push && !full) mq.push_back({b0.avs_address[1:0], b0.avs_writedata});
  endtask

  task automatic tick();
    model_edge();
    @(negedge clk);
  endtask

  task automatic test_reset();
    idle_inputs();
    rst_n = 1'b0;
    repeat (3) tick();
    n_vec++; if (b0.conduit_export_control_set !== 1'b0) begin n_err++; $display("FAIL reset_set got %b exp 0", b0.conduit_export_control_set); end
    n_vec++; if (b0.conduit_export_control_data !== 32'h0) begin n_err++; $display("FAIL reset_data got %h exp 0", b0.conduit_export_control_data); end
    n_vec++; if (b0.conduit_export_control_channel !== 2'd0) begin n_err++; $display("FAIL reset_chan got %h exp 0", b0.conduit_export_control_channel); end
    n_vec++; if (b0.avs_readdata !== 32'h0) begin n_err++; $display("FAIL reset_rdata got %h exp 0", b0.avs_readdata); end
    n_vec++; if (b1.conduit_export_control_set !== 1'b0) begin n_err++; $display("FAIL reset_pulse_set got %b exp 0", b1.conduit_export_control_set); end
    rst_n = 1'b1;
  endtask

  // Push on the very first edge after reset release, ack held high
  task automatic test_single();
    b0.conduit_export_control_ack = 1'b1;
    b0.avs_write = 1'b1; b0.avs_address = 3'd2; b0.avs_writedata = 32'hDEADBEEF;
    tick();
    n_vec++; if (b0.conduit_export_control_set !== 1'b1) begin n_err++; $display("FAIL single_set got %b exp 1", b0.conduit_export_control_set); end
    n_vec++; if (b0.conduit_export_control_data !== 32'hDEADBEEF) begin n_err++; $display("FAIL single_data got %h exp deadbeef", b0.conduit_export_control_data); end
    n_vec++; if (b0.conduit_export_control_channel !== 2'd2) begin n_err++; $display("FAIL single_chan got %h exp 2", b0.conduit_export_control_channel); end
    b0.avs_write = 1'b0; b0.avs_read = 1'b1; b0.avs_address = 3'd4;
    tick();
    n_vec++; if (b0.conduit_export_control_set !== 1'b0) begin n_err++; $display("FAIL single_set_low got %b exp 0", b0.conduit_export_control_set); end
    n_vec++; if (b0.conduit_export_control_data !== 32'h0) begin n_err++; $display("FAIL single_data_low got %h exp 0", b0.conduit_export_control_data); end
    n_vec++; if (b0.avs_readdata !== 32'h0000_0001) begin n_err++; $display("FAIL status_pre_pop got %h exp 00000001", b0.avs_readdata); end
    tick();
    n_vec++; if (b0.avs_readdata !== 32'h0001_0000) begin n_err++; $display("FAIL single_status got %h exp 00010000", b0.avs_readdata); end
    b0.avs_read = 1'b0;
    b0.conduit_export_control_ack = 1'b0;
  endtask

  task automatic test_fill_overflow();
    b0.conduit_export_control_ack = 1'b0;
    for (int i = 0; i < 9; i++) begin
      b0.avs_write = 1'b1; b0.avs_address = 3'(i % 4); b0.avs_writedata = $urandom;
      tick();
    end
    b0.avs_write = 1'b0; b0.avs_read = 1'b1; b0.avs_address = 3'd4;
    tick();
    n_vec++; if (b0.avs_readdata !== 32'h8002_0008) begin n_err++; $display("FAIL fill_status got %h exp 80020008", b0.avs_readdata); end
    n_vec++; if (b0.conduit_export_control_data !== mq[0][31:0]) begin n_err++; $display("FAIL fill_head got %h exp %h", b0.conduit_export_control_data, mq[0][31:0]); end
    b0.avs_read = 1'b0;
  endtask

  task automatic test_full_push_pop();
    b0.conduit_export_control_ack = 1'b1;
    b0.avs_write = 1'b1; b0.avs_address = 3'd1; b0.avs_writedata = 32'h1234_5678;
    tick();
    b0.conduit_export_control_ack = 1'b0;
    b0.avs_write = 1'b0; b0.avs_read = 1'b1; b0.avs_address = 3'd4;
    n_vec++; if (b0.conduit_export_control_data !== mq[0][31:0]) begin n_err++; $display("FAIL fullpp_head got %h exp %h", b0.conduit_export_control_data, mq[0][31:0]); end
    tick();
    n_vec++; if (b0.avs_readdata !== 32'h8000_0007) begin n_err++; $display("FAIL fullpp_status got %h exp 80000007", b0.avs_readdata); end
    b0.avs_read = 1'b0;
  endtask

  task automatic test_ovf_clear();
    b0.avs_write = 1'b1; b0.avs_address = 3'd4; b0.avs_writedata = 32'h8000_0000;
    tick();
    b0.avs_write = 1'b0; b0.avs_read = 1'b1;
    tick();
    n_vec++; if (b0.avs_readdata !== 32'h0000_0007) begin n_err++; $display("FAIL ovf_clear got %h exp 00000007", b0.avs_readdata); end
    b0.avs_read = 1'b0;
    b0.avs_write = 1'b1; b0.avs_address = 3'd3; b0.avs_writedata = $urandom;
    tick();
    b0.avs_writedata = $urandom;
    tick();
    b0.avs_address = 3'd4; b0.avs_writedata = 32'h0000_0001;
    tick();
    b0.avs_write = 1'b0; b0.avs_read = 1'b1;
    tick();
    n_vec++; if (b0.avs_readdata !== 32'h8002_0008) begin n_err++; $display("FAIL ovf_noclr got %h exp 80020008", b0.avs_readdata); end
    b0.avs_read = 1'b0;
    b0.avs_write = 1'b1; b0.avs_address = 3'd4; b0.avs_writedata = 32'h8000_0000;
    tick();
    b0.avs_address = 3'd0; b0.avs_writedata = $urandom;
    tick();
    b0.avs_write = 1'b0; b0.avs_read = 1'b1; b0.avs_address = 3'd4;
    tick();
    n_vec++; if (b0.avs_readdata !== 32'h8002_0008) begin n_err++; $display("FAIL ovf_reset_after_clr got %h exp 80020008", b0.avs_readdata); end
    b0.avs_read = 1'b0;
    b0.avs_write = 1'b1; b0.avs_writedata = 32'hFFFF_FFFF;
    tick();
    b0.avs_write = 1'b0; b0.avs_read = 1'b1;
    tick();
    n_vec++; if (b0.avs_readdata !== 32'h0002_0008) begin n_err++; $display("FAIL ovf_clr2 got %h exp 00020008", b0.avs_readdata); end
    b0.avs_read = 1'b0;
    // Drain everything, checking the order against the model
    b0.conduit_export_control_ack = 1'b1;
    for (int i = 0; i < DEPTH; i++) begin
      n_vec++;
      if (b0.conduit_export_control_set !== 1'b1 || b0.conduit_export_control_data !== mq[0][31:0]) begin
        n_err++; $display("FAIL drain_%0d got %b/%h exp 1/%h", i, b0.conduit_export_control_set, b0.conduit_export_control_data, mq[0][31:0]);
      end
      tick();
    end
    b0.conduit_export_control_ack = 1'b0;
    n_vec++; if (b0.conduit_export_control_set !== 1'b0) begin n_err++; $display("FAIL drain_empty got %b exp 0", b0.conduit_export_control_set); end
  endtask

  task automatic test_random();
    logic        rd_prev;
    logic [33:0] hd;
    int          ack_pct;
    rd_prev = 1'b0;
    for (int i = 0; i < 400; i++) begin
      hd = (mq.size() != 0) ? mq[0] : '0;
      n_vec++; if (b0.conduit_export_control_set !== (mq.size() != 0)) begin n_err++; $display("FAIL rnd_set@%0d got %b exp %b", i, b0.conduit_export_control_set, (mq.size() != 0)); end
      n_vec++; if (b0.conduit_export_control_data !== hd[31:0]) begin n_err++; $display("FAIL rnd_data@%0d got %h exp %h", i, b0.conduit_export_control_data, hd[31:0]); end
      n_vec++; if (b0.conduit_export_control_channel !== hd[33:32]) begin n_err++; $display("FAIL rnd_chan@%0d got %h exp %h", i, b0.conduit_export_control_channel, hd[33:32]); end
      if (rd_prev) begin
        n_vec++; if (b0.avs_readdata !== mrd) begin n_err++; $display("FAIL rnd_rdata@%0d got %h exp %h", i, b0.avs_readdata, mrd); end
      end
      ack_pct = 10 + 30 * ((i / 50) % 4);
      b0.conduit_export_control_ack = ($urandom_range(0, 99) < ack_pct);
      b0.avs_write = ($urandom_range(0, 99) < 60);
      b0.avs_address = ($urandom_range(0, 9) < 8) ? 3'($urandom_range(0, 3)) : 3'($urandom_range(4, 7));
      b0.avs_writedata = $urandom;
      if (b0.avs_write && b0.avs_address == 3'd4 && $urandom_range(0, 3) != 0)
        b0.avs_address = 3'($urandom_range(0, 3));
      b0.avs_read = ($urandom_range(0, 1) == 1);
      if (b0.avs_read && !b0.avs_write)
        b0.avs_address = ($urandom_range(0, 3) != 0) ? 3'd4 : 3'($urandom_range(0, 7));
      rd_prev = b0.avs_read;
      tick();
    end
    if (rd_prev) begin
      n_vec++; if (b0.avs_readdata !== mrd) begin n_err++; $display("FAIL rnd_rdata_last got %h exp %h", b0.avs_readdata, mrd); end
    end
    idle_inputs();
  endtask

  // Pulse-mode instance: three pushes with ack low must give three isolated one-cycle pulses in order
  task automatic test_pulse();
    logic [31:0] w[3];
    logic [1:0]  c[3];
    logic        s_set[12];
    logic [31:0] s_dat[12];
    logic [1:0]  s_ch[12];
    int          np;
    int          adj;
    for (int k = 0; k < 3; k++) begin w[k] = $urandom; c[k] = 2'($urandom_range(0, 3)); end
    b1.conduit_export_control_ack = 1'b0;
    b1.avs_write = 1'b1; b1.avs_address = {1'b0, c[0]}; b1.avs_writedata = w[0];
    tick();
    for (int k = 0; k < 12; k++) begin
      s_set[k] = b1.conduit_export_control_set;
      s_dat[k] = b1.conduit_export_control_data;
      s_ch[k]  = b1.conduit_export_control_channel;
      if (k < 2) begin
        b1.avs_address = {1'b0, c[k+1]}; b1.avs_writedata = w[k+1];
      end else begin
        b1.avs_write = 1'b0;
      end
      tick();
    end
    np = 0; adj = 0;
    for (int k = 0; k < 12; k++) begin
      if (s_set[k]) begin
        if (k > 0 && s_set[k-1]) adj++;
        if (np < 3) begin
          n_vec++; if (s_dat[k] !== w[np] || s_ch[k] !== c[np]) begin n_err++; $display("FAIL pulse_word_%0d got %h/%0d exp %h/%0d", np, s_dat[k], s_ch[k], w[np], c[np]); end
        end
        np++;
      end else begin
        n_vec++; if (s_dat[k] !== 32'h0 || s_ch[k] !== 2'd0) begin n_err++; $display("FAIL pulse_idle_zero@%0d got %h/%0d exp 0/0", k, s_dat[k], s_ch[k]); end
      end
    end
    n_vec++; if (np !== 3) begin n_err++; $display("FAIL pulse_count got %0d exp 3", np); end
    n_vec++; if (adj !== 0) begin n_err++; $display("FAIL pulse_gap got %0d adjacent highs exp 0", adj); end
    idle_inputs();
  endtask

  task automatic test_reset_mid();
    b0.conduit_export_control_ack = 1'b0;
    for (int i = 0; i < 5; i++) begin
      b0.avs_write = 1'b1; b0.avs_address = 3'(i % 4); b0.avs_writedata = $urandom;
      tick();
    end
    b0.avs_write = 1'b0;
    n_vec++; if (b0.conduit_export_control_set !== 1'b1) begin n_err++; $display("FAIL midrst_pre_set got %b exp 1", b0.conduit_export_control_set); end
    rst_n = 1'b0;
    #1;
    n_vec++; if (b0.conduit_export_control_set !== 1'b0) begin n_err++; $display("FAIL midrst_async_set got %b exp 0", b0.conduit_export_control_set); end
    n_vec++; if (b0.conduit_export_control_data !== 32'h0) begin n_err++; $display("FAIL midrst_async_data got %h exp 0", b0.conduit_export_control_data); end
    repeat (2) tick();
    rst_n = 1'b1;
    b0.conduit_export_control_ack = 1'b1;
    for (int i = 0; i < 6; i++) begin
      tick();
      n_vec++; if (b0.conduit_export_control_set !== 1'b0) begin n_err++; $display("FAIL midrst_stale@%0d got %b exp 0", i, b0.conduit_export_control_set); end
    end
    b0.avs_read = 1'b1; b0.avs_address = 3'd4;
    tick();
    n_vec++; if (b0.avs_readdata !== 32'h0001_0000) begin n_err++; $display("FAIL midrst_status got %h exp 00010000", b0.avs_readdata); end
    idle_inputs();
  endtask

  initial begin
    idle_inputs();
    @(negedge clk);
    test_reset();
    test_single();
    test_fill_overflow();
    test_full_push_pop();
    test_ovf_clear();
    test_random();
    test_pulse();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
